esc_pwm_multi_axi: RTL and testbench
====================================

Name: esc_pwm_multi_axi

Overview:
- Parametrised multi-channel ESC (electronic speed controller) PWM generator with an AXI4-Lite slave register interface.
- Successor to the single-channel esc_controller IP. Adds:
  - NUM_CH channels sharing one frame counter.
  - Frame-synchronous shadow loading of pulse widths.
  - A programmable period.
  - A command watchdog that forces failsafe pulses.
- Sits behind the AXI interconnect; pwm_out drives motor ESC pins.

Parameters:
- NUM_CH, 4, number of PWM channels (1..12).
- C_S_AXI_DATA_WIDTH, 32, AXI data width (fixed 32).
- C_S_AXI_ADDR_WIDTH, 6, AXI address width (byte address).
- PERIOD_DEFAULT, 125000, reset frame length in ACLK cycles (2.5 ms at 50 MHz).
- FAILSAFE_PULSE, 50000, reset/failsafe pulse width in cycles (1.0 ms).
- WDT_DEFAULT, 25000000, reset watchdog timeout in cycles (0.5 s).

Ports:
- ACLK  in  1  clock
- ARESETN  in  1  reset
- s_axi_awaddr  in  C_S_AXI_ADDR_WIDTH  write address
- s_axi_awprot  in  3  ignored
- s_axi_awvalid / s_axi_awready  in/out  1  AW handshake
- s_axi_wdata  in  32  write data
- s_axi_wstrb  in  4  byte strobes
- s_axi_wvalid / s_axi_wready  in/out  1  W handshake
- s_axi_bresp  out  2  write response
- s_axi_bvalid / s_axi_bready  out/in  1  B handshake
- s_axi_araddr  in  C_S_AXI_ADDR_WIDTH  read address
- s_axi_arprot  in  3  ignored
- s_axi_arvalid / s_axi_arready  in/out  1  AR handshake
- s_axi_rdata  out  32  read data
- s_axi_rresp  out  2  read response
- s_axi_rvalid / s_axi_rready  out/in  1  R handshake
- pwm_out  out  NUM_CH  PWM outputs
- frame_start  out  1  one-cycle pulse at each frame wrap

Behaviour:
- Single clock ACLK; reset ARESETN is asynchronous, active-low. All outputs are 0 in reset; registers take the reset values below.

Register map (word-aligned, addr[1:0] ignored):
- 0x00 CTRL rw: bit0 EN, bit1 WDT_EN; reset 0.
- 0x04 PERIOD rw: [23:0]; reset PERIOD_DEFAULT. Values <2 are treated as 2.
- 0x08 STATUS ro: bit0 FAILSAFE. Writes are accepted (OKAY) and ignored.
- 0x0C WDT rw: [31:0]; reset WDT_DEFAULT.
- 0x10+4n CHn rw, n<NUM_CH: [23:0]; reset FAILSAFE_PULSE.
- Any other address: write ignored with BRESP=SLVERR(2'b10); read returns RDATA=0 with RRESP=SLVERR. Unused register bits read 0.
- WSTRB is honoured per byte.

AXI write path:
- AWREADY and WREADY are asserted together for one cycle, only when AWVALID&&WVALID&&!BVALID.
- Register update happens on that cycle.
- BVALID is asserted on the next cycle and held until BREADY.
- Only one write is outstanding at a time.

AXI read path:
- ARREADY is pulsed for one cycle when ARVALID&&!RVALID.
- RDATA/RVALID are presented on the next cycle and held until RREADY.
- Read and write channels are independent; simultaneous activity is allowed.

Frame counter:
- cnt runs 0..P-1, where P is the PERIOD value latched at the previous wrap.
- When EN=0, cnt is held at 0 and pwm_out=0 immediately (next edge).
- On the cycle cnt wraps from P-1 to 0:
  - frame_start=1.
  - Shadow PERIOD is loaded.
  - Each shadow[n] is loaded with CHn, or with FAILSAFE_PULSE when FAILSAFE=1.
- On the EN 0→1 edge, shadows are loaded and frame_start pulses on the first cycle.

PWM output:
- pwm_out[n] = EN && (cnt < shadow[n]), registered; one cycle latency from cnt.
- shadow=0 gives a constant low output; shadow≥P gives a constant high output.
- A CHn write mid-frame has no effect until the next wrap.

Watchdog:
- Counter wd increments while WDT_EN=1.
- wd resets to 0 on any accepted CHn write, and when WDT_EN=0.
- FAILSAFE sets when wd reaches WDT, and clears on the next CHn write.
- Failsafe pulses apply from the next frame load.
- WDT=0 means FAILSAFE sets one cycle after WDT_EN is raised.

Test Plan:
- Reset, then read 0x00/0x04/0x08/0x0C/0x10 → 0, 125000, 0, 25000000, 50000; all RRESP=OKAY; pwm_out=0.
- Write PERIOD=100, CH0=25, CH1=0, CH2=100, CH3=200, then CTRL=1 → every 100 cycles frame_start pulses; ch0 is high 25 cycles; ch1 is always low; ch2 and ch3 are always high.
- Mid-frame write CH0=60 (at cnt=10) → current frame stays 25 high; next frame 60 high. Write-readback of CH0 returns 0x0000003C.
- WDT=500, CTRL=3, no CH writes → STATUS=1 after 500 cycles; next frame all channels pulse 50000-clamped (≥P → high). Write CH0=25 → STATUS=0; next frame resumes programmed widths.
- Write 0xDEADBEEF to CH0 with WSTRB=4'b0001, then read → 0x000000EF. Access 0x3C → BRESP/RRESP=2'b10, RDATA=0.
- Assert ARESETN=0 mid-frame with BVALID pending → pwm_out, frame_start, BVALID and RVALID drop to 0 asynchronously; registers return to reset values.

Source files
------------

// File: rtl/esc_pwm_multi_axi.sv
// Multi-channel ESC PWM generator with an AXI4-Lite register file.
// Channels share one frame counter; widths and period reload only at frame wraps.
module esc_pwm_multi_axi #(
    parameter int NUM_CH             = 4,
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 6,
    parameter int PERIOD_DEFAULT     = 125000,
    parameter int FAILSAFE_PULSE     = 50000,
    parameter int WDT_DEFAULT        = 25000000
) (
    input  logic                            ACLK,
    input  logic                            ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [2:0]                      s_axi_awprot,
    input  logic                            s_axi_awvalid,
    output logic                            s_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
    input  logic                            s_axi_wvalid,
    output logic                            s_axi_wready,
    output logic [1:0]                      s_axi_bresp,
    output logic                            s_axi_bvalid,
    input  logic                            s_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [2:0]                      s_axi_arprot,
    input  logic                            s_axi_arvalid,
    output logic                            s_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]                      s_axi_rresp,
    output logic                            s_axi_rvalid,
    input  logic                            s_axi_rready,
    output logic [NUM_CH-1:0]               pwm_out,
    output logic                            frame_start
);

    localparam int IDX_W     = C_S_AXI_ADDR_WIDTH - 2;
    localparam int NUM_WORDS = 1 << IDX_W;

    localparam logic [23:0] PERIOD_RST = 24'(PERIOD_DEFAULT);
    localparam logic [23:0] FS_PULSE   = 24'(FAILSAFE_PULSE);
    localparam logic [31:0] WDT_RST    = 32'(WDT_DEFAULT);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic              ctrl_en;
    logic              ctrl_wdt_en;
    logic [23:0]       period_reg;
    logic [31:0]       wdt_reg;
    logic [23:0]       ch_reg [NUM_CH];
    logic              failsafe;

    logic              wr_ready_q;
    logic              rd_ready_q;
    logic              wr_en;
    logic              ch_wr;
    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  rd_idx;
    logic              wr_idx_ok;
    logic              rd_idx_ok;
    logic [31:0]       reg_word [NUM_WORDS];
    logic [31:0]       wr_merged;

    logic [23:0]       cnt;
    logic [23:0]       period_sh;
    logic [23:0]       period_next;
    logic [23:0]       shadow [NUM_CH];
    logic              en_d;
    logic              run;
    logic              load;
    logic [31:0]       wd;

    logic              unused_ok;

    assign unused_ok = ^{s_axi_awprot, s_axi_arprot,
                         s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
        logic [31:0] r;
        for (int b = 0; b < 4; b++)
            r[b*8 +: 8] = strb[b] ? new_val[b*8 +: 8] : old_val[b*8 +: 8];
        return r;
    endfunction

    assign s_axi_awready = wr_ready_q;
    assign s_axi_wready  = wr_ready_q;
    assign s_axi_arready = rd_ready_q;

    assign wr_idx    = s_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:2];
    assign rd_idx    = s_axi_araddr[C_S_AXI_ADDR_WIDTH-1:2];
    assign wr_idx_ok = 32'(wr_idx) < 32'(4 + NUM_CH);
    assign rd_idx_ok = 32'(rd_idx) < 32'(4 + NUM_CH);
    assign wr_en     = wr_ready_q && s_axi_awvalid && s_axi_wvalid;
    assign ch_wr     = wr_en && wr_idx_ok && (wr_idx >= IDX_W'(4));

    // Register view shared by the read mux and the byte-strobe merge.
    always_comb begin
        for (int i = 0; i < NUM_WORDS; i++)
            reg_word[i] = 32'd0;
        reg_word[0] = {30'd0, ctrl_wdt_en, ctrl_en};
        reg_word[1] = {8'd0, period_reg};
        reg_word[2] = {31'd0, failsafe};
        reg_word[3] = wdt_reg;
        for (int n = 0; n < NUM_CH; n++)
            reg_word[4 + n] = {8'd0, ch_reg[n]};
    end

    assign wr_merged = apply_strb(reg_word[wr_idx], s_axi_wdata, s_axi_wstrb);

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            wr_ready_q   <= 1'b0;
            s_axi_bvalid <= 1'b0;
            s_axi_bresp  <= RESP_OKAY;
            ctrl_en      <= 1'b0;
            ctrl_wdt_en  <= 1'b0;
            period_reg   <= PERIOD_RST;
            wdt_reg      <= WDT_RST;
            for (int n = 0; n < NUM_CH; n++)
                ch_reg[n] <= FS_PULSE;
        end else begin
            wr_ready_q <= !wr_ready_q && s_axi_awvalid && s_axi_wvalid && !s_axi_bvalid;
            if (wr_en) begin
                s_axi_bvalid <= 1'b1;
                s_axi_bresp  <= wr_idx_ok ? RESP_OKAY : RESP_SLVERR;
                if (wr_idx == IDX_W'(0)) begin
                    ctrl_en     <= wr_merged[0];
                    ctrl_wdt_en <= wr_merged[1];
                end
                if (wr_idx == IDX_W'(1))
                    period_reg <= wr_merged[23:0];
                if (wr_idx == IDX_W'(3))
                    wdt_reg <= wr_merged;
                for (int n = 0; n < NUM_CH; n++)
                    if (wr_idx == IDX_W'(4 + n))
                        ch_reg[n] <= wr_merged[23:0];
            end else if (s_axi_bvalid && s_axi_bready) begin
                s_axi_bvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            rd_ready_q   <= 1'b0;
            s_axi_rvalid <= 1'b0;
            s_axi_rdata  <= '0;
            s_axi_rresp  <= RESP_OKAY;
        end else begin
            rd_ready_q <= !rd_ready_q && s_axi_arvalid && !s_axi_rvalid;
            if (rd_ready_q && s_axi_arvalid) begin
                s_axi_rvalid <= 1'b1;
                s_axi_rdata  <= reg_word[rd_idx];
                s_axi_rresp  <= rd_idx_ok ? RESP_OKAY : RESP_SLVERR;
            end else if (s_axi_rvalid && s_axi_rready) begin
                s_axi_rvalid <= 1'b0;
            end
        end
    end

    // Watchdog saturates at the timeout so FAILSAFE stays asserted until a channel write.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            wd       <= 32'd0;
            failsafe <= 1'b0;
        end else if (ch_wr) begin
            wd       <= 32'd0;
            failsafe <= 1'b0;
        end else if (!ctrl_wdt_en) begin
            wd <= 32'd0;
        end else begin
            if (wd >= wdt_reg)
                failsafe <= 1'b1;
            else
                wd <= wd + 32'd1;
        end
    end

    // The first enabled cycle is treated like a wrap so a fresh frame starts with cnt=0.
    assign run         = ctrl_en && en_d;
    assign load        = ctrl_en && (!en_d || (cnt == period_sh - 24'd1));
    assign period_next = (period_reg < 24'd2) ? 24'd2 : period_reg;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            cnt         <= 24'd0;
            en_d        <= 1'b0;
            period_sh   <= PERIOD_RST;
            frame_start <= 1'b0;
            pwm_out     <= '0;
            for (int n = 0; n < NUM_CH; n++)
                shadow[n] <= FS_PULSE;
        end else begin
            en_d        <= ctrl_en;
            frame_start <= load;
            if (!ctrl_en || load)
                cnt <= 24'd0;
            else
                cnt <= cnt + 24'd1;
            if (load) begin
                period_sh <= period_next;
                for (int n = 0; n < NUM_CH; n++)
                    shadow[n] <= failsafe ? FS_PULSE : ch_reg[n];
            end
            for (int n = 0; n < NUM_CH; n++)
                pwm_out[n] <= run && (cnt < shadow[n]);
        end
    end

endmodule

// File: tb/tb_esc_pwm_multi_axi.sv
// Directed bench for esc_pwm_multi_axi: register access, frame timing, watchdog, reset.
// A negedge monitor records per-frame high counts and frame length for the checks.
module tb_esc_pwm_multi_axi;

    localparam int NUM_CH = 4;

    logic              tb_ACLK = 1'b0;
    logic              tb_ARESETN;
    logic [5:0]        s_axi_awaddr;
    logic [2:0]        s_axi_awprot;
    logic              s_axi_awvalid;
    logic              s_axi_awready;
    logic [31:0]       s_axi_wdata;
    logic [3:0]        s_axi_wstrb;
    logic              s_axi_wvalid;
    logic              s_axi_wready;
    logic [1:0]        s_axi_bresp;
    logic              s_axi_bvalid;
    logic              s_axi_bready;
    logic [5:0]        s_axi_araddr;
    logic [2:0]        s_axi_arprot;
    logic              s_axi_arvalid;
    logic              s_axi_arready;
    logic [31:0]       s_axi_rdata;
    logic [1:0]        s_axi_rresp;
    logic              s_axi_rvalid;
    logic              s_axi_rready;
    logic [NUM_CH-1:0] pwm_out;
    logic              frame_start;

    int checks = 0;
    int errors = 0;
    int hi_acc  [NUM_CH] = '{default: 0};
    int hi_last [NUM_CH] = '{default: 0};
    int frame_cnt   = 0;
    int cyc         = 0;
    int last_fs_cyc = 0;
    int last_period = 0;

    always #5 tb_ACLK = ~tb_ACLK;

    esc_pwm_multi_axi dut (
        .ACLK          (tb_ACLK),
        .ARESETN       (tb_ARESETN),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_awprot  (s_axi_awprot),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (s_axi_awready),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wstrb   (s_axi_wstrb),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (s_axi_wready),
        .s_axi_bresp   (s_axi_bresp),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bready  (s_axi_bready),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arprot  (s_axi_arprot),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rresp   (s_axi_rresp),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready),
        .pwm_out       (pwm_out),
        .frame_start   (frame_start)
    );

    // A frame owns the samples after its frame_start up to and including the next one.
    always @(negedge tb_ACLK) begin
        cyc++;
        for (int n = 0; n < NUM_CH; n++)
            if (pwm_out[n]) hi_acc[n]++;
        if (frame_start) begin
            for (int n = 0; n < NUM_CH; n++) begin
                hi_last[n] = hi_acc[n];
                hi_acc[n]  = 0;
            end
            last_period = cyc - last_fs_cyc;
            last_fs_cyc = cyc;
            frame_cnt++;
        end
    end

    task automatic axi_write(input logic [5:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp);
        int n;
        @(posedge tb_ACLK); #1;
        s_axi_awaddr  = addr;
        s_axi_wdata   = data;
        s_axi_wstrb   = strb;
        s_axi_awvalid = 1'b1;
        s_axi_wvalid  = 1'b1;
        n = 0;
        do begin @(posedge tb_ACLK); #1; n++; end while (!s_axi_awready && n < 50);
        checks++;
        if (!s_axi_awready) begin
            errors++;
            $display("[TB] FAIL awready_timeout addr=%h: got 0 expected 1", addr);
        end
        @(posedge tb_ACLK); #1;
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        n = 0;
        while (!s_axi_bvalid && n < 50) begin @(posedge tb_ACLK); #1; n++; end
        checks++;
        if (!s_axi_bvalid) begin
            errors++;
            $display("[TB] FAIL bvalid_timeout addr=%h: got 0 expected 1", addr);
        end
        resp = s_axi_bresp;
        s_axi_bready = 1'b1;
        @(posedge tb_ACLK); #1;
        s_axi_bready = 1'b0;
    endtask

    task automatic axi_read(input logic [5:0] addr, output logic [31:0] data,
                            output logic [1:0] resp);
        int n;
        @(posedge tb_ACLK); #1;
        s_axi_araddr  = addr;
        s_axi_arvalid = 1'b1;
        n = 0;
        do begin @(posedge tb_ACLK); #1; n++; end while (!s_axi_arready && n < 50);
        @(posedge tb_ACLK); #1;
        s_axi_arvalid = 1'b0;
        n = 0;
        while (!s_axi_rvalid && n < 50) begin @(posedge tb_ACLK); #1; n++; end
        checks++;
        if (!s_axi_rvalid) begin
            errors++;
            $display("[TB] FAIL rvalid_timeout addr=%h: got 0 expected 1", addr);
        end
        data = s_axi_rdata;
        resp = s_axi_rresp;
        s_axi_rready = 1'b1;
        @(posedge tb_ACLK); #1;
        s_axi_rready = 1'b0;
    endtask

    task automatic wait_frame();
        int start;
        int n;
        start = frame_cnt;
        n = 0;
        while (frame_cnt == start && n < 1000) begin @(negedge tb_ACLK); #1; n++; end
        if (frame_cnt == start) begin
            checks++;
            errors++;
            $display("[TB] FAIL frame_timeout: got no frame_start expected one within 1000 cycles");
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic [1:0]  r;
        logic [5:0]  addrs [5] = '{6'h00, 6'h04, 6'h08, 6'h0C, 6'h10};
        logic [31:0] exps  [5] = '{32'd0, 32'd125000, 32'd0, 32'd25000000, 32'd50000};
        tb_ARESETN = 1'b0;
        repeat (3) @(posedge tb_ACLK);
        #1;
        checks++;
        if (pwm_out !== 4'b0000 || frame_start !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got pwm=%b fs=%b expected 0000/0", pwm_out, frame_start);
        end
        checks++;
        if (s_axi_bvalid !== 1'b0 || s_axi_rvalid !== 1'b0 || s_axi_awready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_axi: got bvalid=%b rvalid=%b awready=%b expected 0",
                     s_axi_bvalid, s_axi_rvalid, s_axi_awready);
        end
        tb_ARESETN = 1'b1;
        for (int i = 0; i < 5; i++) begin
            axi_read(addrs[i], d, r);
            checks++;
            if (d !== exps[i] || r !== 2'b00) begin
                errors++;
                $display("[TB] FAIL reset_reg_%h: got %h/%b expected %h/00", addrs[i], d, r, exps[i]);
            end
        end
        axi_read(6'h1C, d, r);
        checks++;
        if (d !== 32'd50000 || r !== 2'b00) begin
            errors++;
            $display("[TB] FAIL reset_ch3: got %h/%b expected %h/00", d, r, 32'd50000);
        end
        checks++;
        if (pwm_out !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL idle_pwm: got %b expected 0000", pwm_out);
        end
    endtask

    task automatic test_pwm();
        logic [1:0]  r;
        logic [5:0]  addrs [5] = '{6'h04, 6'h10, 6'h14, 6'h18, 6'h1C};
        logic [31:0] vals  [5] = '{32'd100, 32'd25, 32'd0, 32'd100, 32'd200};
        int          exp_hi [NUM_CH] = '{25, 0, 100, 100};
        for (int i = 0; i < 5; i++) begin
            axi_write(addrs[i], vals[i], 4'hF, r);
            checks++;
            if (r !== 2'b00) begin
                errors++;
                $display("[TB] FAIL cfg_bresp_%h: got %b expected 00", addrs[i], r);
            end
        end
        axi_write(6'h00, 32'd1, 4'hF, r);
        repeat (3) wait_frame();
        checks++;
        if (last_period !== 100) begin
            errors++;
            $display("[TB] FAIL frame_period: got %0d expected 100", last_period);
        end
        for (int n = 0; n < NUM_CH; n++) begin
            checks++;
            if (hi_last[n] !== exp_hi[n]) begin
                errors++;
                $display("[TB] FAIL pwm_width_ch%0d: got %0d expected %0d", n, hi_last[n], exp_hi[n]);
            end
        end
    endtask

    task automatic test_mid_frame();
        logic [31:0] d;
        logic [1:0]  r;
        wait_frame();
        repeat (10) @(posedge tb_ACLK);
        axi_write(6'h10, 32'd60, 4'hF, r);
        wait_frame();
        checks++;
        if (hi_last[0] !== 25) begin
            errors++;
            $display("[TB] FAIL mid_frame_current: got %0d expected 25", hi_last[0]);
        end
        wait_frame();
        checks++;
        if (hi_last[0] !== 60) begin
            errors++;
            $display("[TB] FAIL mid_frame_next: got %0d expected 60", hi_last[0]);
        end
        axi_read(6'h10, d, r);
        checks++;
        if (d !== 32'h0000003C) begin
            errors++;
            $display("[TB] FAIL ch0_readback: got %h expected 0000003c", d);
        end
    endtask

    task automatic test_watchdog();
        logic [31:0] d;
        logic [1:0]  r;
        axi_write(6'h0C, 32'd500, 4'hF, r);
        axi_write(6'h00, 32'd3, 4'hF, r);
        axi_read(6'h08, d, r);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("[TB] FAIL status_before_timeout: got %h expected 0", d);
        end
        repeat (600) @(posedge tb_ACLK);
        axi_read(6'h08, d, r);
        checks++;
        if (d !== 32'd1) begin
            errors++;
            $display("[TB] FAIL status_after_timeout: got %h expected 1", d);
        end
        repeat (2) wait_frame();
        for (int n = 0; n < NUM_CH; n++) begin
            checks++;
            if (hi_last[n] !== 100) begin
                errors++;
                $display("[TB] FAIL failsafe_width_ch%0d: got %0d expected 100", n, hi_last[n]);
            end
        end
        axi_write(6'h10, 32'd25, 4'hF, r);
        axi_read(6'h08, d, r);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("[TB] FAIL status_after_ch_write: got %h expected 0", d);
        end
        repeat (2) wait_frame();
        checks++;
        if (hi_last[0] !== 25 || hi_last[1] !== 0) begin
            errors++;
            $display("[TB] FAIL resume_widths: got %0d/%0d expected 25/0", hi_last[0], hi_last[1]);
        end
        axi_write(6'h00, 32'd1, 4'hF, r);
    endtask

    task automatic test_strobe_decode();
        logic [31:0] d;
        logic [1:0]  r;
        axi_write(6'h10, 32'hDEADBEEF, 4'b0001, r);
        axi_read(6'h10, d, r);
        checks++;
        if (d !== 32'h000000EF || r !== 2'b00) begin
            errors++;
            $display("[TB] FAIL strobe_ch0: got %h/%b expected 000000ef/00", d, r);
        end
        axi_write(6'h0C, 32'h11223344, 4'b1010, r);
        axi_read(6'h0C, d, r);
        checks++;
        if (d !== 32'h110033F4) begin
            errors++;
            $display("[TB] FAIL strobe_wdt: got %h expected 110033f4", d);
        end
        axi_write(6'h3C, 32'h12345678, 4'hF, r);
        checks++;
        if (r !== 2'b10) begin
            errors++;
            $display("[TB] FAIL bad_addr_bresp: got %b expected 10", r);
        end
        axi_read(6'h3C, d, r);
        checks++;
        if (d !== 32'd0 || r !== 2'b10) begin
            errors++;
            $display("[TB] FAIL bad_addr_read: got %h/%b expected 00000000/10", d, r);
        end
        axi_write(6'h08, 32'd1, 4'hF, r);
        checks++;
        if (r !== 2'b00) begin
            errors++;
            $display("[TB] FAIL status_write_bresp: got %b expected 00", r);
        end
        axi_read(6'h08, d, r);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("[TB] FAIL status_ro: got %h expected 0", d);
        end
    endtask

    task automatic test_period_clamp();
        logic [1:0] r;
        axi_write(6'h04, 32'd0, 4'hF, r);
        repeat (3) wait_frame();
        checks++;
        if (last_period !== 2 || hi_last[0] !== 2 || hi_last[1] !== 0) begin
            errors++;
            $display("[TB] FAIL period_clamp: got P=%0d ch0=%0d ch1=%0d expected 2/2/0",
                     last_period, hi_last[0], hi_last[1]);
        end
        axi_write(6'h04, 32'd100, 4'hF, r);
        repeat (2) wait_frame();
        checks++;
        if (last_period !== 100) begin
            errors++;
            $display("[TB] FAIL period_restore: got %0d expected 100", last_period);
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] d;
        logic [1:0]  r;
        int          n;
        @(posedge tb_ACLK); #1;
        s_axi_awaddr  = 6'h14;
        s_axi_wdata   = 32'd5;
        s_axi_wstrb   = 4'hF;
        s_axi_awvalid = 1'b1;
        s_axi_wvalid  = 1'b1;
        n = 0;
        do begin @(posedge tb_ACLK); #1; n++; end while (!s_axi_awready && n < 50);
        @(posedge tb_ACLK); #1;
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        s_axi_araddr  = 6'h00;
        s_axi_arvalid = 1'b1;
        n = 0;
        do begin @(posedge tb_ACLK); #1; n++; end while (!s_axi_arready && n < 50);
        @(posedge tb_ACLK); #1;
        s_axi_arvalid = 1'b0;
        checks++;
        if (s_axi_bvalid !== 1'b1 || s_axi_rvalid !== 1'b1 || pwm_out === 4'b0000) begin
            errors++;
            $display("[TB] FAIL pre_reset_state: got bvalid=%b rvalid=%b pwm=%b expected 1/1/nonzero",
                     s_axi_bvalid, s_axi_rvalid, pwm_out);
        end
        #2;
        tb_ARESETN = 1'b0;
        #1;
        checks++;
        if (pwm_out !== 4'b0000 || frame_start !== 1'b0) begin
            errors++;
            $display("[TB] FAIL async_reset_pwm: got pwm=%b fs=%b expected 0000/0", pwm_out, frame_start);
        end
        checks++;
        if (s_axi_bvalid !== 1'b0 || s_axi_rvalid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL async_reset_axi: got bvalid=%b rvalid=%b expected 0/0",
                     s_axi_bvalid, s_axi_rvalid);
        end
        repeat (2) @(posedge tb_ACLK);
        #1;
        tb_ARESETN = 1'b1;
        axi_read(6'h00, d, r);
        checks++;
        if (d !== 32'd0) begin
            errors++;
            $display("[TB] FAIL post_reset_ctrl: got %h expected 0", d);
        end
        axi_read(6'h04, d, r);
        checks++;
        if (d !== 32'd125000) begin
            errors++;
            $display("[TB] FAIL post_reset_period: got %0d expected 125000", d);
        end
        axi_read(6'h14, d, r);
        checks++;
        if (d !== 32'd50000) begin
            errors++;
            $display("[TB] FAIL post_reset_ch1: got %0d expected 50000", d);
        end
        checks++;
        if (pwm_out !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL post_reset_pwm: got %b expected 0000", pwm_out);
        end
    endtask

    initial begin
        tb_ARESETN    = 1'b0;
        s_axi_awaddr  = '0;
        s_axi_awprot  = '0;
        s_axi_awvalid = 1'b0;
        s_axi_wdata   = '0;
        s_axi_wstrb   = '0;
        s_axi_wvalid  = 1'b0;
        s_axi_bready  = 1'b0;
        s_axi_araddr  = '0;
        s_axi_arprot  = '0;
        s_axi_arvalid = 1'b0;
        s_axi_rready  = 1'b0;
        $display("[TB] starting esc_pwm_multi_axi bench");
        test_reset();
        test_pwm();
        test_mid_frame();
        test_watchdog();
        test_strobe_decode();
        test_period_clamp();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
